// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with a synchroniser, a frame FSM and a word FIFO
//
// Ports:
//   clk        - single clock, rising edge
//   rstN       - asynchronous active-low reset
//   rx         - asynchronous serial input, idles high
//   rx_data    - data bits of the FIFO head word (0 when empty)
//   rx_valid   - FIFO not empty
//   rx_ready   - consumer accept; pop when rx_valid && rx_ready
//   parity_err - parity-error flag of the head word
//   frame_err  - framing-error flag of the head word
//   overrun    - one-cycle pulse when a completed frame is dropped on a full FIFO
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_rx_fifo: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
        $error("uart_rx_fifo: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx_fifo: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = 4;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = DATA_BITS + 2;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);
    localparam logic          ODD_PAR   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // Synchroniser
    logic rx_meta_q, rx_sync_q;

    // Frame FSM
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 push;
    logic [WW-1:0]        push_word;

    // FIFO
    logic [WW-1:0] mem_q [FIFO_DEPTH];
    logic [WW-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          overrun_q, overrun_d;
    logic          empty, full, pop, wr_en;
    logic [WW-1:0] head;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                // Mid-bit recheck rejects glitches shorter than half a bit
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = (^shift_q) ^ rx_sync_q ^ ODD_PAR;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~rx_sync_q;
                    if (idx_q == STOP_LAST) begin
                        push  = 1'b1;
                        idx_d = '0;
                        // A low last stop sample always carries frame_err, so it
                        // is treated as the start of a break condition.
                        state_d = rx_sync_q ? S_IDLE : S_BREAK;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The word includes the frame_err contribution of the current stop sample
    assign push_word = {shift_q, perr_q, ferr_d};

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && rx_ready;
    // When full, a simultaneous pop frees the head slot that the write reuses
    assign wr_en = push && (!full || pop);

    always_comb begin
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        overrun_d = push && full && !pop;
        if (wr_en) begin
            mem_d[wr_q[AW-1:0]] = push_word;
            wr_d                = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            overrun_q <= overrun_d;
            mem_q     <= mem_d;
        end
    end

    assign head       = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign rx_valid   = !empty;
    assign rx_data    = head[WW-1:2];
    assign parity_err = head[1];
    assign frame_err  = head[0];
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (8N1 instance and 8E1 instance)
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB   = 32;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, rx_valid_p;
    logic       rx_ready;
    logic       rx_ready_p;
    logic       parity_err, parity_err_p;
    logic       frame_err, frame_err_p;
    logic       overrun, overrun_p;

    logic ready_man = 1'b0;
    logic rand_mode = 1'b0;
    logic rand_bit  = 1'b0;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int exp_ovr = 0;

    // Expected words: {data[7:0], parity_err, frame_err}
    logic [9:0] exp_q[$];
    logic [9:0] exp_p_q[$];

    assign rx_ready   = rand_mode ? rand_bit : ready_man;
    assign rx_ready_p = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
        .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstN(rstN), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun)
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
        .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut_p (
        .clk(clk), .rstN(rstN), .rx(rx_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
        .rx_ready(rx_ready_p), .parity_err(parity_err_p), .frame_err(frame_err_p),
        .overrun(overrun_p)
    );

    always @(posedge clk) rand_bit <= 1'($urandom_range(0, 1));

    // Monitors: compare every popped word against the scoreboard head
    always @(negedge clk) begin
        if (rstN && rx_valid && rx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word8n1: got %h/%b/%b, required no word", rx_data, parity_err, frame_err);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({rx_data, parity_err, frame_err} !== e) begin
                    errors++;
                    $display("FAIL word8n1: got %h/%b/%b, required %h/%b/%b",
                             rx_data, parity_err, frame_err, e[9:2], e[1], e[0]);
                end
            end
        end
        if (rstN && rx_valid_p && rx_ready_p) begin
            checks++;
            if (exp_p_q.size() == 0) begin
                errors++;
                $display("FAIL word8e1: got %h/%b/%b, required no word", rx_data_p, parity_err_p, frame_err_p);
            end else begin
                logic [9:0] e;
                e = exp_p_q.pop_front();
                if ({rx_data_p, parity_err_p, frame_err_p} !== e) begin
                    errors++;
                    $display("FAIL word8e1: got %h/%b/%b, required %h/%b/%b",
                             rx_data_p, parity_err_p, frame_err_p, e[9:2], e[1], e[0]);
                end
            end
        end
        if (overrun) ovr_cnt++;
        if (overrun_p) begin
            checks++;
            errors++;
            $display("FAIL overrun8e1: got 1, required 0");
        end
    end

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic bit_wait();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit which, input logic v);
        if (which) rx_p = v;
        else rx = v;
    endtask

    // Reference model: word content from the transmitted bits; a frame that
    // completes while four words are waiting and nobody reads is dropped.
    task automatic model_push(input bit which, input logic [7:0] d, input logic pbit, input logic stop_v);
        logic pe;
        pe = which ? (((^d) ^ pbit) != 1'b0) : 1'b0;
        if (which) begin
            exp_p_q.push_back({d, pe, ~stop_v});
        end else if (exp_q.size() >= DEPTH && !rx_ready) begin
            exp_ovr++;
        end else begin
            exp_q.push_back({d, pe, ~stop_v});
        end
    endtask

    task automatic send_frame(input bit which, input logic [7:0] d, input logic pbit, input logic stop_v);
        drive(which, 1'b0);
        bit_wait();
        for (int i = 0; i < 8; i++) begin
            drive(which, d[i]);
            bit_wait();
        end
        if (which) begin
            drive(which, pbit);
            bit_wait();
        end
        model_push(which, d, pbit, stop_v);
        drive(which, stop_v);
        bit_wait();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(rx_valid), 0);
        check("reset_data", int'(rx_data), 0);
        check("reset_perr", int'(parity_err), 0);
        check("reset_ferr", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        @(negedge clk);
        rstN = 1'b1;
        ready_man = 1'b1;
        bit_wait();

        // Plain 8N1 word
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
        bit_wait();
        check("a5_drained", exp_q.size(), 0);

        // Parity error on the 8E1 instance
        send_frame(1'b1, 8'h03, 1'b1, 1'b1);
        bit_wait();
        check("parity_drained", exp_p_q.size(), 0);

        // Framing error followed by a 20-bit break, then a clean frame
        send_frame(1'b0, 8'h55, 1'b0, 1'b0);
        repeat (20) bit_wait();
        check("break_one_word", exp_q.size(), 0);
        check("break_valid", int'(rx_valid), 0);
        rx = 1'b1;
        bit_wait();
        bit_wait();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        bit_wait();
        check("after_break_drained", exp_q.size(), 0);

        // Glitch of 8 clocks: nothing pushed
        rx = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rx = 1'b1;
        bit_wait();
        bit_wait();
        check("glitch_valid", int'(rx_valid), 0);

        // Overrun on the fifth back-to-back frame
        ready_man = 1'b0;
        for (int k = 1; k <= 4; k++) send_frame(1'b0, 8'(k), 1'b0, 1'b1);
        check("ovr_before", ovr_cnt, 0);
        check("full_valid", int'(rx_valid), 1);
        send_frame(1'b0, 8'h05, 1'b0, 1'b1);
        check("ovr_after", ovr_cnt, 1);
        check("ovr_model", exp_ovr, 1);
        ready_man = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drained_valid", int'(rx_valid), 0);
        check("drained_queue", exp_q.size(), 0);

        // Reset in the middle of data bit 3 with a word already waiting
        ready_man = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b1);
        rx = 1'b0;
        bit_wait();
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            bit_wait();
        end
        rx = 1'b1;
        repeat (10) @(posedge clk);
        check("pre_reset_valid", int'(rx_valid), 1);
        #3;
        rstN = 1'b0;
        #1;
        check("reset_mid_valid", int'(rx_valid), 0);
        check("reset_mid_data", int'(rx_data), 0);
        exp_q.delete();
        repeat (5) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        ready_man = 1'b1;
        bit_wait();
        bit_wait();
        check("post_reset_valid", int'(rx_valid), 0);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1);
        bit_wait();
        check("c3_drained", exp_q.size(), 0);

        // Random data with a randomly stalling consumer
        rand_mode = 1'b1;
        for (int k = 0; k < 20; k++) send_frame(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        for (int k = 0; k < 8; k++)
            send_frame(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
        rand_mode = 1'b0;
        bit_wait();
        bit_wait();
        check("final_queue", exp_q.size(), 0);
        check("final_queue_p", exp_p_q.size(), 0);
        check("final_overruns", ovr_cnt, exp_ovr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 32, meaning clocks per UART bit; legal range >= 4.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY_EN, default 0; 1 means a parity bit follows the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0; 0 means even parity, 1 means odd parity; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, meaning received-word buffer depth; power of 2, >= 2.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 rstN  input  1  reset, asynchronous assert, active-low.
REQ-009 rx  input  1  asynchronous UART serial line; idles high.
REQ-010 rx_data  output  DATA_BITS  data of the FIFO head word.
REQ-011 rx_valid  output  1  FIFO not empty.
REQ-012 rx_ready  input  1  consumer accept; a pop occurs when rx_valid && rx_ready.
REQ-013 parity_err  output  1  parity-error flag of the head word.
REQ-014 frame_err  output  1  framing-error flag of the head word.
REQ-015 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-016 SHALL pass rx through a 2-flop synchroniser; both flops reset to 1; all frame logic uses the synchronised value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP and BREAK, with a bit-timing counter and a bit index.
REQ-018 IDLE: synchronised rx == 0 -> START with the counter cleared.
REQ-019 START: at count CLKS_PER_BIT/2-1, sample rx; 1 -> IDLE (glitch, nothing pushed); 0 -> DATA with the counter cleared.
REQ-020 DATA: sample every CLKS_PER_BIT clocks; bits arrive LSB first; after DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
REQ-021 PARITY: sample one bit; parity_err = (XOR of data bits ^ sampled bit) != PARITY_ODD.
REQ-022 STOP: sample STOP_BITS bits at CLKS_PER_BIT spacing; any 0 sample sets frame_err for the word.
REQ-023 On the last stop sample, SHALL push {data, parity_err, frame_err} in the same cycle.
REQ-024 After the push: rx == 1 -> IDLE; rx == 0 with frame_err -> BREAK.
REQ-025 BREAK: wait for synchronised rx == 1, then -> IDLE; no further words are pushed during the break.
REQ-026 Latency: rx_valid SHALL rise on the clock edge following the push cycle when the FIFO was empty.
REQ-027 FIFO order SHALL be first-in first-out; rx_data, parity_err and frame_err SHALL reflect the head word whenever rx_valid=1.
REQ-028 Push while full with no pop SHALL drop the new word, leave the FIFO unchanged and pulse overrun for 1 cycle.
REQ-029 Push while full with a simultaneous pop SHALL accept both; no overrun.
REQ-030 Pop while empty SHALL be ignored; rx_ready has no effect when rx_valid=0.
REQ-031 Read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full/empty SHALL be decoded from the MSB difference.
REQ-032 Parameters outside their legal ranges SHALL cause an elaboration-time error.

Reset
REQ-033 rstN low SHALL immediately force: state IDLE, counters 0, FIFO empty, rx_valid 0, rx_data 0, parity_err 0, frame_err 0, overrun 0.
REQ-034 A frame in progress when rstN asserts SHALL be discarded; after rstN deasserts, reception re-arms on the next falling edge of synchronised rx.

Verification
REQ-035 Defaults, rx_ready=1, send 0xA5 as 8N1 at 320 ns per bit (10 ns clk) -> exactly one word: rx_data=0xA5, parity_err=0, frame_err=0.
REQ-036 PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1.
REQ-037 Send 0x55 with stop bit 0, then hold rx low for 20 bit times -> one word, rx_data=0x55, frame_err=1; no further words until rx returns high; the next 0x3C frame is received cleanly.
REQ-038 rx_ready=0, send 0x01..0x05 back-to-back -> overrun pulses once, during the 0x05 push; then rx_ready=1 reads 0x01, 0x02, 0x03, 0x04 in order, then rx_valid=0.
REQ-039 Drive an rx low pulse of 8 clocks -> no word pushed; state back to IDLE.
REQ-040 Assert rstN during data bit 3 of a frame -> rx_valid=0 immediately; the following 0xC3 frame is received correctly.
